// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and defaults for the SPI responder
// Contents:
//   spi_slv_state_t  responder FSM states
//   SPI_WIDTH        default frame length in bits
//   SPI_SYNC_STAGES  default synchronizer depth on the async SPI inputs
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEADIN,
    SHIFT,
    WAIT_CS
  } spi_slv_state_t;

  localparam int SPI_WIDTH       = 12;
  localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage synchronizer with rise/fall pulse outputs
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   din         asynchronous input
//   dout        synchronized level
//   rise, fall  one-cycle pulses on synchronized 0->1 / 1->0 transitions
// Parameters:
//   STAGES   flop stages (minimum 2)
//   RST_VAL  idle level of the input; every stage resets to it so that
//            leaving reset never produces a spurious edge
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - oversampling full-duplex SPI responder, LSB-first frames
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   sclk, cs, mosi        SPI bus from the master (async to clk, cs active-low)
//   miso                  serial response to the master
//   tx_data/tx_valid      response word for the next frame; tx_ready pulses on accept
//   rx_data/rx_valid      last received word, held until rx_ready
//   rx_overrun            pulse: an unread word was overwritten
//   frame_err             pulse: cs rose before a full frame was received
// Build option:
//   SPI_SLAVE_LOOPBACK_EN  each frame echoes the last completed rx word on miso;
//                          tx_data/tx_valid are ignored and tx_ready stays 0
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overrun,
  output logic             frame_err
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .dout(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(cs),
    .dout(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  // Same depth as sclk so the data bit and its sampling edge stay aligned.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi),
    .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Only edges are needed for sclk/cs and only the level for mosi.
  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

  spi_slv_state_t   state_q, state_d;
  logic [WIDTH-1:0] txsh_q, txsh_d;
  logic [WIDTH-1:0] rxsh_q, rxsh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             miso_q, miso_d;
  logic             tx_ready_q, tx_ready_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_overrun_q, rx_overrun_d;
  logic             frame_err_q, frame_err_d;

`ifdef SPI_SLAVE_LOOPBACK_EN
  logic unused_tx;
  assign unused_tx = ^{tx_data, tx_valid};
`endif

  always_comb begin
    state_d      = state_q;
    txsh_d       = txsh_q;
    rxsh_d       = rxsh_q;
    cnt_d        = cnt_q;
    miso_d       = miso_q;
    tx_ready_d   = 1'b0;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q & ~rx_ready;
    rx_overrun_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          cnt_d   = '0;
          rxsh_d  = '0;
          state_d = LEADIN;
`ifdef SPI_SLAVE_LOOPBACK_EN
          // rx_data_q always holds the most recent completed word, read or not.
          txsh_d = rx_data_q;
`else
          if (tx_valid) begin
            txsh_d     = tx_data;
            tx_ready_d = 1'b1;
          end else begin
            txsh_d = '0;
          end
`endif
        end
      end

      // The sclk fall right after cs goes low carries no data.
      LEADIN: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (sclk_fall) begin
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          if (sclk_rise) begin
            miso_d = txsh_q[0];
            txsh_d = {1'b0, txsh_q[WIDTH-1:1]};
          end
          if (sclk_fall) begin
            // Enter at the MSB end: after WIDTH samples bit 0 sits at index 0.
            rxsh_d = {mosi_s, rxsh_q[WIDTH-1:1]};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              // A coincident rx_ready consumed the old word, so no overrun.
              rx_data_d    = rxsh_d;
              rx_valid_d   = 1'b1;
              rx_overrun_d = rx_valid_q & ~rx_ready;
              miso_d       = 1'b0;
              state_d      = WAIT_CS;
            end
          end
        end
      end

      WAIT_CS: begin
        miso_d = 1'b0;
        if (cs_rise) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      txsh_q       <= '0;
      rxsh_q       <= '0;
      cnt_q        <= '0;
      miso_q       <= 1'b0;
      tx_ready_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      txsh_q       <= txsh_d;
      rxsh_q       <= rxsh_d;
      cnt_q        <= cnt_d;
      miso_q       <= miso_d;
      tx_ready_q   <= tx_ready_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign miso       = miso_q;
  assign tx_ready   = tx_ready_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// tb/tb_spi_slave_if.sv - self-checking bench for spi_slave_if with a frame-level model
module tb_spi_slave_if;
  import spi_pkg::*;

  localparam int W    = SPI_WIDTH;
  localparam int SYNC = SPI_SYNC_STAGES;
  localparam int HALF = 6;

  logic         clk = 1'b0;
  logic         rst_n, sclk, cs, mosi, miso;
  logic [W-1:0] tx_data, rx_data;
  logic         tx_valid, tx_ready, rx_valid, rx_ready, rx_overrun, frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txr    = 0;
  int n_ovr    = 0;
  int n_ferr   = 0;

  logic [W-1:0] m_rx_data;
  bit           m_rx_valid;

  always #5 clk = ~clk;

  spi_slave_if dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (tx_ready)   n_txr++;
    if (rx_overrun) n_ovr++;
    if (frame_err)  n_ferr++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_wait(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_miso"},       miso,       0);
    check_eq({tag, "_tx_ready"},   tx_ready,   0);
    check_eq({tag, "_rx_data"},    rx_data,    0);
    check_eq({tag, "_rx_valid"},   rx_valid,   0);
    check_eq({tag, "_rx_overrun"}, rx_overrun, 0);
    check_eq({tag, "_frame_err"},  frame_err,  0);
  endtask

  // Master side: cs low on a rise, lead-in fall, bit i on rise i+1, cs high one rise later.
  task automatic spi_frame(input logic [W-1:0] din, input int nbits, input bit rst_mid,
                           output logic [W-1:0] mw);
    bit lat_chk;
    lat_chk = (nbits == W) && !m_rx_valid && !rst_mid;
    mw = '0;
    sclk = 1'b1; cs = 1'b0; drive_wait(HALF);
    sclk = 1'b0;            drive_wait(HALF);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1; mosi = din[i];
      drive_wait(HALF);
      mw[i] = miso;
      sclk = 1'b0;
      if (lat_chk && i == nbits - 1) begin
        for (int k = 1; k <= HALF; k++) begin
          @(posedge clk); #1;
          if (k == SYNC)     check_eq("rx_valid_early",   rx_valid, 0);
          if (k == SYNC + 1) check_eq("rx_valid_latency", rx_valid, 1);
        end
        #2;
      end else begin
        drive_wait(HALF);
      end
    end
    if (rst_mid) begin
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
      drive_wait(4);
      rst_n = 1'b1;
      drive_wait(HALF);
    end else begin
      sclk = 1'b1; cs = 1'b1; drive_wait(HALF);
      sclk = 1'b0;            drive_wait(HALF);
    end
  endtask

  task automatic run_frame(input logic [W-1:0] din, input int nbits,
                           input logic [W-1:0] txd, input bit txv, input bit rst_mid);
    logic [W-1:0] mw, exp_miso, mask;
    int           txr0, ovr0, ferr0, exp_ovr, exp_ferr, exp_txr;
    tx_data = txd; tx_valid = txv;
`ifdef SPI_SLAVE_LOOPBACK_EN
    exp_miso = m_rx_data;
    exp_txr  = 0;
`else
    exp_miso = txv ? txd : '0;
    exp_txr  = txv ? 1 : 0;
`endif
    mask     = (nbits >= W) ? {W{1'b1}} : W'((1 << nbits) - 1);
    exp_ovr  = (nbits == W && !rst_mid && m_rx_valid) ? 1 : 0;
    exp_ferr = (nbits < W && !rst_mid) ? 1 : 0;
    txr0 = n_txr; ovr0 = n_ovr; ferr0 = n_ferr;
    spi_frame(din, nbits, rst_mid, mw);
    tx_valid = 1'b0;
    if (rst_mid) begin
      m_rx_data  = '0;
      m_rx_valid = 1'b0;
    end else if (nbits == W) begin
      m_rx_data  = din;
      m_rx_valid = 1'b1;
    end
    check_eq("miso_word",  mw & mask, exp_miso & mask);
    check_eq("tx_ready_n", n_txr - txr0, exp_txr);
    check_eq("overrun_n",  n_ovr - ovr0, exp_ovr);
    check_eq("frame_err_n", n_ferr - ferr0, exp_ferr);
    check_eq("rx_data",    rx_data,  m_rx_data);
    check_eq("rx_valid",   rx_valid, m_rx_valid);
  endtask

  task automatic do_read();
    rx_ready = 1'b1;
    drive_wait(1);
    rx_ready = 1'b0;
    m_rx_valid = 1'b0;
    check_eq("rx_valid_after_read", rx_valid, 0);
  endtask

  initial begin
    logic [W-1:0] rd, rt;
    int           nb;
    rst_n = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
    m_rx_data = '0; m_rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    #2;
    rst_n = 1'b1;
    drive_wait(4);

    run_frame(12'hA5C, W, 12'h3F1, 1'b1, 1'b0);
    do_read();

    run_frame(12'h001, W, 12'h2C4, 1'b1, 1'b0);
    run_frame(12'hFFF, W, 12'h000, 1'b0, 1'b0);
    do_read();

    run_frame(12'h0F0, 5, 12'h0AA, 1'b1, 1'b0);
    run_frame(12'h123, W, 12'h456, 1'b1, 1'b0);
    do_read();

    run_frame(12'h6B2, W, 12'hABC, 1'b0, 1'b0);

    run_frame(12'h777, 5, 12'h555, 1'b1, 1'b1);
    run_frame(12'h800, W, 12'h5A5, 1'b1, 1'b0);
    run_frame(12'h5A5, W, 12'h0C3, 1'b1, 1'b0);
    do_read();

    for (int r = 0; r < 12; r++) begin
      rd = W'($urandom);
      rt = W'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : W;
      run_frame(rd, nb, rt, 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 1) == 1) do_read();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
